tdm_demux_receiver: RTL and testbench
=====================================

// Module: tdm_demux_receiver
// PURPOSE
//  Receive end of the 4-lane time-multiplexed serial link: the transmit side's mux
//  drives one lane per cycle onto a single wire (select 00 -> in[3] ... 11 -> in[0]).
//  This block re-assembles each frame of WIDTH serial bits into a parallel word.
//  It tracks the current lane as both an encoded index and a one-hot code (00 -> 1000).
//  Completed words go out through a valid/ready handshake.
// PARAMETERS
//  WIDTH   4  lanes per frame = bits in data_out; power of 2, >= 2
//  SEL_W   2  lane index width; must equal clog2(WIDTH)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous reset, active low
//  ser_in       in   1      serial lane bit
//  ser_valid    in   1      ser_in carries a lane bit this cycle
//  frame_start  in   1      qualifies the current ser_valid bit as lane 0
//  data_out     out  WIDTH  assembled word, lane 0 in bit WIDTH-1
//  out_valid    out  1      data_out holds an unconsumed word
//  out_ready    in   1      consumer accepts data_out on this edge
//  lane_sel     out  SEL_W  index of the next lane expected
//  lane_onehot  out  WIDTH  one-hot lane_sel: lane k -> bit WIDTH-1-k set
//  busy         out  1      a frame is partially received (state SHIFT)
//  overrun      out  1      sticky: a completed word was dropped
// BEHAVIOUR
//  Reset (rst_n low, async, no clock needed): state=IDLE, shreg=0, data_out=0, out_valid=0.
//   Also: lane_sel=0, lane_onehot=1000 (bit WIDTH-1 only), busy=0, overrun=0.
//  All registered outputs update on rising clk edges only.
//  lane_onehot is decoded from lane_sel and is never all-zero.
//  FSM: two states, IDLE and SHIFT. busy=1 exactly in SHIFT.
//  IDLE:
//   - ser_valid && frame_start: shreg[WIDTH-1] <= ser_in, lane_sel <= 1, go to SHIFT.
//   - Any other input combination: ignored; state and lane_sel hold.
//  SHIFT, on each edge with ser_valid=1 and frame_start=0:
//   - shreg[WIDTH-1-lane_sel] <= ser_in, then lane_sel <= lane_sel+1.
//  SHIFT with ser_valid=0: gap cycle; everything holds, no timeout.
//  Frame completion: the edge that samples lane WIDTH-1.
//   - The assembled word (shreg plus this bit) is offered to the output.
//   - lane_sel wraps to 0, go to IDLE.
//   - out_valid is visible the cycle after that edge (latency 1 from last bit).
//  Resync: ser_valid && frame_start while in SHIFT.
//   - Partial frame discarded; this bit is taken as lane 0; lane_sel <= 1; stay in SHIFT.
//   - No flag is raised.
//  Handshake:
//   - Transfer occurs on an edge with out_valid=1 && out_ready=1; out_valid then clears.
//   - data_out is stable while out_valid=1.
//   - out_ready is ignored while out_valid=0.
//  Completion and output, simultaneous events:
//   - out_valid=0: load data_out, out_valid <= 1.
//   - out_valid=1 and out_ready=1 (same edge): new word replaces data_out, out_valid stays 1.
//   - out_valid=1 and out_ready=0: new word dropped, data_out unchanged, overrun <= 1.
//  overrun clears only on reset. Receive keeps running while out_valid is held.
//  Reset mid-frame aborts the frame: no partial word ever appears on data_out.
// TESTING
//  1 Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 at once, lane_onehot=4'b1000.
//  2 Basic frame:
//    - Stimulus: bits 1,0,1,1 on consecutive ser_valid cycles, frame_start with the first, out_ready=1.
//    - Response: data_out=4'b1011; out_valid high one cycle after the 4th bit edge, low the next.
//    - lane_onehot steps 1000 -> 0100 -> 0010 -> 0001 -> 1000.
//  3 Gaps: same bits with ser_valid low 2 cycles between each bit.
//    - Response: data_out=4'b1011, lane_sel holds through gaps, busy=1 throughout.
//  4 Backpressure:
//    - Stimulus: out_ready=0, frame 1011 then frame 0110.
//    - Response: data_out stays 1011, overrun=1; raise out_ready -> out_valid drops, overrun stays 1.
//  5 Resync: 2 bits of a frame, then frame_start with bits 0,0,0,1 -> data_out=4'b0001, no overrun.
//  6 Mid-frame reset: pulse rst_n low after 2 bits -> busy=0, out_valid=0; next frame 1100 -> data_out=4'b1100.

Source files
------------

// File: rtl/tdm_demux_if.sv
// -----------------------------------------------------------------------------
// tdm_demux_if
// Bundle of the serial-in / parallel-out signals of the TDM demux receiver.
//
// Signals
//   ser_in       serial lane bit
//   ser_valid    ser_in carries a lane bit this cycle
//   frame_start  qualifies the current ser_valid bit as lane 0
//   data_out     assembled word, lane 0 in bit WIDTH-1
//   out_valid    data_out holds an unconsumed word
//   out_ready    consumer accepts data_out on this edge
//   lane_sel     index of the next lane expected
//   lane_onehot  one-hot lane_sel: lane k -> bit WIDTH-1-k set
//   busy         a frame is partially received
//   overrun      sticky: a completed word was dropped
//
// Modports
//   master  link source / word consumer side (drives serial inputs, out_ready)
//   slave   receiver side (tdm_demux_receiver)
// -----------------------------------------------------------------------------
interface tdm_demux_if #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
);
  logic             ser_in;
  logic             ser_valid;
  logic             frame_start;
  logic [WIDTH-1:0] data_out;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] lane_sel;
  logic [WIDTH-1:0] lane_onehot;
  logic             busy;
  logic             overrun;

  modport master (
    output ser_in, ser_valid, frame_start, out_ready,
    input  data_out, out_valid, lane_sel, lane_onehot, busy, overrun
  );

  modport slave (
    input  ser_in, ser_valid, frame_start, out_ready,
    output data_out, out_valid, lane_sel, lane_onehot, busy, overrun
  );
endinterface

// File: rtl/tdm_demux_receiver.sv
// -----------------------------------------------------------------------------
// tdm_demux_receiver
// Receive end of a time-multiplexed serial link. One lane bit arrives per
// ser_valid cycle; frame_start marks lane 0. WIDTH lane bits are assembled
// into a parallel word (lane 0 in the MSB) and offered on a valid/ready
// output. A word completed while the previous one is still held and not
// being accepted is dropped and flagged on the sticky overrun output.
//
// Parameters
//   WIDTH  lanes per frame = bits in data_out (power of 2, >= 2)
//   SEL_W  lane index width, must equal $clog2(WIDTH)
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous reset, active low
//   bus    tdm_demux_if.slave (serial input, word output, lane status)
// -----------------------------------------------------------------------------
module tdm_demux_receiver #(
  parameter int WIDTH = 4,
  parameter int SEL_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  tdm_demux_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] lane_q, lane_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic             start;     // lane-0 bit, valid in either state (resync in SHIFT)
  logic             take;      // continuation bit inside a frame
  logic             complete;  // this edge samples the last lane
  logic [SEL_W-1:0] bit_idx;
  logic [WIDTH-1:0] word;      // shreg with the current bit merged in

  // Lane k lands in bit WIDTH-1-k; with WIDTH a power of two that index is
  // simply the bitwise inverse of the lane number.
  assign bit_idx  = ~lane_q;
  assign start    = bus.ser_valid && bus.frame_start;
  assign take     = bus.ser_valid && !bus.frame_start && (state_q == SHIFT);
  assign complete = take && (lane_q == SEL_W'(WIDTH - 1));

  always_comb begin
    word          = shreg_q;
    word[bit_idx] = bus.ser_in;
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: state register + next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane_q  <= '0;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      shreg_q <= shreg_d;
    end
  end

  // NOTE: every signal written here gets its hold value first, so no path
  // through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    shreg_d = shreg_q;
    if (start) begin
      // New frame, or resync: any partial frame is discarded silently.
      shreg_d          = '0;
      shreg_d[WIDTH-1] = bus.ser_in;
      lane_d           = SEL_W'(1);
      state_d          = SHIFT;
    end else if (take) begin
      shreg_d = word;
      if (complete) begin
        lane_d  = '0;
        state_d = IDLE;
      end else begin
        lane_d  = lane_q + SEL_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register and handshake
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (complete) begin
      // Slot is free, or the held word leaves on this same edge: the new
      // word takes its place. Otherwise the new word is lost.
      if (!valid_q || bus.out_ready) begin
        data_d  = word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.data_out    = data_q;
  assign bus.out_valid   = valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.lane_sel    = lane_q;
  assign bus.busy        = (state_q == SHIFT);
  // Lane 0 decodes to the MSB; the shift never empties the vector.
  assign bus.lane_onehot = {1'b1, {(WIDTH-1){1'b0}}} >> lane_q;

endmodule

// File: tb/tb_tdm_demux_receiver.sv
// -----------------------------------------------------------------------------
// tb_tdm_demux_receiver
// Self-checking bench for tdm_demux_receiver. A frame-level reference model
// (a queue of received lane bits plus a one-word output slot) predicts every
// completed word and pushes it into a scoreboard queue; a negedge monitor
// compares the DUT's status outputs against the model and pops/compares
// data_out whenever the DUT presents a word that is being accepted.
// -----------------------------------------------------------------------------
module tb_tdm_demux_receiver;

  localparam int WIDTH = 4;
  localparam int SEL_W = 2;

  logic clk;
  logic rst_n;

  tdm_demux_if #(.WIDTH(WIDTH), .SEL_W(SEL_W)) bus ();

  tdm_demux_receiver #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit             m_bits[$];       // lane bits of the frame in progress
  bit             m_in_frame = 0;
  bit             m_occ      = 0;  // output slot holds a word
  bit             m_ovr      = 0;
  logic [WIDTH-1:0] exp_q[$];      // scoreboard: words the DUT must present

  function automatic int m_lane();
    return m_in_frame ? m_bits.size() : 0;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_in_frame = 0;
    m_occ      = 0;
    m_ovr      = 0;
    exp_q.delete();
  endtask

  // Applies the inputs that were present at the edge just taken.
  task automatic model_step(input bit sv, input bit fs, input bit si, input bit rdy);
    bit               got;
    logic [WIDTH-1:0] w;
    got = 0;
    w   = '0;
    if (sv && fs) begin
      m_bits.delete();
      m_bits.push_back(si);
      m_in_frame = 1;
    end else if (sv && m_in_frame) begin
      m_bits.push_back(si);
      if (m_bits.size() == WIDTH) begin
        for (int i = 0; i < WIDTH; i++) w[WIDTH-1-i] = m_bits[i];
        got = 1;
        m_bits.delete();
        m_in_frame = 0;
      end
    end
    if (got) begin
      if (!m_occ || rdy) begin
        exp_q.push_back(w);
        m_occ = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_occ && rdy) begin
      m_occ = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_oh;
    exp_oh = WIDTH'(1) << (WIDTH - 1 - m_lane());
    check("out_valid",   32'(bus.out_valid),   32'(m_occ));
    check("busy",        32'(bus.busy),        32'(m_in_frame));
    check("lane_sel",    32'(bus.lane_sel),    32'(m_lane()));
    check("lane_onehot", 32'(bus.lane_onehot), 32'(exp_oh));
    check("overrun",     32'(bus.overrun),     32'(m_ovr));
    if (bus.out_valid) begin
      check("sb_depth", 32'(exp_q.size()), 32'd1);
      if (exp_q.size() > 0) begin
        check("sb_data", 32'(bus.data_out), 32'(exp_q[0]));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at posedge+1, return at posedge+1)
  // ---------------------------------------------------------------------------
  task automatic cycle(input bit sv, input bit fs, input bit si, input bit rdy);
    bus.ser_valid   = sv;
    bus.frame_start = fs;
    bus.ser_in      = si;
    bus.out_ready   = rdy;
    @(posedge clk);
    model_step(sv, fs, si, rdy);
    #1;
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] w, input int gap, input bit rdy);
    for (int i = 0; i < WIDTH; i++) begin
      cycle(1'b1, i == 0, w[WIDTH-1-i], rdy);
      if (i != WIDTH - 1)
        for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, 1'($urandom), rdy);
    end
  endtask

  // Asserts reset between clock edges and checks the outputs before any edge.
  task automatic do_reset();
    bus.ser_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.ser_in      = 1'b0;
    bus.out_ready   = 1'b0;
    @(posedge clk);
    model_step(1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_out_valid",   32'(bus.out_valid),   32'd0);
    check("rst_data_out",    32'(bus.data_out),    32'd0);
    check("rst_overrun",     32'(bus.overrun),     32'd0);
    check("rst_lane_sel",    32'(bus.lane_sel),    32'd0);
    check("rst_lane_onehot", 32'(bus.lane_onehot), 32'b1000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [WIDTH-1:0] basic;
    logic [WIDTH-1:0] oh_after[WIDTH];
    bit sv, fs;

    basic       = 4'b1011;
    oh_after[0] = 4'b0100;
    oh_after[1] = 4'b0010;
    oh_after[2] = 4'b0001;
    oh_after[3] = 4'b1000;

    rst_n           = 1'b0;
    bus.ser_in      = 1'b0;
    bus.ser_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.out_ready   = 1'b0;
    do_reset();

    // Basic frame 1011 with the consumer ready.
    for (int i = 0; i < WIDTH; i++) begin
      cycle(1'b1, i == 0, basic[WIDTH-1-i], 1'b1);
      check("basic_onehot", 32'(bus.lane_onehot), 32'(oh_after[i]));
    end
    check("basic_valid", 32'(bus.out_valid), 32'd1);
    check("basic_data",  32'(bus.data_out),  32'b1011);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("basic_valid_drop", 32'(bus.out_valid), 32'd0);

    // Same frame with two gap cycles between bits.
    for (int i = 0; i < WIDTH; i++) begin
      cycle(1'b1, i == 0, basic[WIDTH-1-i], 1'b1);
      if (i != WIDTH - 1) begin
        for (int g = 0; g < 2; g++) begin
          cycle(1'b0, 1'b0, 1'($urandom), 1'b1);
          check("gap_lane", 32'(bus.lane_sel), 32'(i + 1));
          check("gap_busy", 32'(bus.busy),     32'd1);
        end
      end
    end
    check("gap_data", 32'(bus.data_out), 32'b1011);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Resync: two bits of a frame, then a fresh frame 0001.
    do_reset();
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    send_frame(4'b0001, 0, 1'b1);
    check("resync_data",    32'(bus.data_out), 32'b0001);
    check("resync_overrun", 32'(bus.overrun),  32'd0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Backpressure: second word is dropped and overrun sticks.
    send_frame(4'b1011, 0, 1'b0);
    send_frame(4'b0110, 0, 1'b0);
    check("bp_data",    32'(bus.data_out),  32'b1011);
    check("bp_overrun", 32'(bus.overrun),   32'd1);
    check("bp_valid",   32'(bus.out_valid), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_release_valid",   32'(bus.out_valid), 32'd0);
    check("bp_release_overrun", 32'(bus.overrun),   32'd1);

    // Mid-frame reset, then a clean frame 1100.
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 1'b0, 1'b1, 1'b1);
    do_reset();
    send_frame(4'b1100, 0, 1'b1);
    check("postrst_data", 32'(bus.data_out), 32'b1100);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic: gaps, resyncs and backpressure mixed.
    for (int n = 0; n < 600; n++) begin
      sv = ($urandom_range(0, 3) != 0);
      fs = sv && ($urandom_range(0, 5) == 0);
      cycle(sv, fs, 1'($urandom), ($urandom_range(0, 2) != 0));
    end

    for (int n = 0; n < 3; n++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
